seven_seg_scan_decoder: RTL and testbench
=========================================

# seven_seg_scan_decoder

Monitor-side decoder for the multiplexed four-digit seven-segment bus. It samples the active-low digit-enable and segment-data lines that the display driver produces. It deglitches each enable/data pair, inverts the segment encoding back to a 4-bit nibble per digit, and publishes a coherent four-nibble frame once every digit has been seen. It sits beside the display path for self-test and bring-up: the SD readout value can be checked end-to-end against what the display is actually showing.

## Interface
Parameters:
- STABLE_CYCLES, 4: consecutive identical registered samples required before a pair is accepted (min 2).
- TIMEOUT_CYCLES, 1024: clock cycles without a valid digit write before a stall is flagged.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- sevenSegmentEnable  input  4  active-low digit enable; 1110=digit A, 1101=B, 1011=C, 0111=D.
- sevenSegmentData  input  8  active-low segment pattern, bit 7 first in the strings below.
- nibbleA, nibbleB, nibbleC, nibbleD  output  4 each  last complete decoded frame.
- frameValid  output  1  one-cycle pulse when nibbleA..D update.
- patternError  output  1  one-cycle pulse on acceptance of an undecodable pattern.
- errorCount  output  8  saturating count of patternError pulses.
- scanStalled  output  1  high while no valid digit write has occurred for TIMEOUT_CYCLES.

## Operation
- Input stage: both buses are registered every edge. On reset, the input stage loads enable 4'b1111 and data 8'hFF.
- Stability filter:
  - stableCount clears when the registered pair differs from the previous registered pair, and otherwise increments, saturating.
  - A pair is accepted exactly once, when it has been identical for STABLE_CYCLES consecutive registered samples.
  - It is not re-accepted until the pair changes.
- Accepted pair with invalid enable (not exactly one bit low, including 1111 blanking): no write, no error, no mask change.
- Accepted pair with valid enable: data is decoded with an exact 8-bit match:
  - 0=00010001, 1=11010111, 2=00110010, 3=10010010
  - 4=11010100, 5=10011000, 6=00011000, 7=11010011
  - 8=00010000, 9=10010000, A=01010000, b=00011100
  - C=00111001, d=00010110, E=00111000, F=01111000
- Decode match: the nibble is written to that digit's internal capture register and its bit in the 4-bit seenMask is set. Rewriting an already-seen digit overwrites it; the mask is unchanged.
- Decode miss:
  - patternError pulses and errorCount increments, saturating at 255.
  - That digit's seenMask bit clears; the capture register is unchanged.
- Frame completion: when a write makes seenMask 1111, all four capture values, including the digit being written, are copied to nibbleA..D and frameValid pulses. seenMask clears on the same edge.
- Stall timer:
  - Clears on every valid digit write and otherwise increments.
  - On reaching TIMEOUT_CYCLES, scanStalled asserts and seenMask clears. The timer holds.
  - scanStalled deasserts on the edge of the next valid digit write.
- Reset, including mid-frame: all outputs 0; capture registers, seenMask, stableCount and stall timer cleared.

## Timing
- Let e be the first edge that registers a new pair. Acceptance effects (capture write, frameValid, patternError, errorCount, scanStalled clear) are visible after edge e+STABLE_CYCLES.
- A pair held for fewer than STABLE_CYCLES edges is never accepted.
- frameValid and patternError are single-cycle pulses and never both high; a pattern miss cannot complete a frame.
- nibbleA..D change only on the frameValid edge and hold between frames.
- scanStalled asserts TIMEOUT_CYCLES edges after the last valid write, or after reset release.
- A valid write and timer expiry on the same edge: the write wins; the timer clears and scanStalled stays low.

## Test plan
- Scan 1110/10010010, 1101/01010000, 1011/00010001, 0111/01111000, 8 cycles each -> one frameValid pulse at the fourth acceptance; nibbleA=3, B=A, C=0, D=F; errorCount=0.
- Hold a pair for 3 cycles (STABLE_CYCLES=4), then change it -> no write and no pulse. Then hold for exactly 4 cycles -> accepted, with effects visible after edge e+4.
- Capture A and C, then present 1101/11111111 for 8 cycles -> one patternError pulse, errorCount=1, B mask bit clear. A later valid B and D -> frame with the new B.
- Hold 1111/11111111 from reset release -> scanStalled rises after edge 1024. The next valid digit write clears it; a full frame is then required again.
- Capture three digits, assert reset for 2 cycles, release, then scan all four -> all outputs 0 during reset and exactly one frameValid after the fourth post-reset digit.
- Alternate 1110/00000000 with 1111/11111111, 300 times -> errorCount saturates at 255; patternError continues to pulse.

Source files
------------

// File: rtl/seven_seg_scan_decoder_if.sv
// Bus bundle for the seven-segment scan monitor: sampled display lines in,
// decoded frame and health status out.
interface seven_seg_scan_decoder_if;
    logic [3:0] sevenSegmentEnable;
    logic [7:0] sevenSegmentData;
    logic [3:0] nibbleA;
    logic [3:0] nibbleB;
    logic [3:0] nibbleC;
    logic [3:0] nibbleD;
    logic       frameValid;
    logic       patternError;
    logic [7:0] errorCount;
    logic       scanStalled;

    modport slave (
        input  sevenSegmentEnable, sevenSegmentData,
        output nibbleA, nibbleB, nibbleC, nibbleD,
        output frameValid, patternError, errorCount, scanStalled
    );

    modport master (
        output sevenSegmentEnable, sevenSegmentData,
        input  nibbleA, nibbleB, nibbleC, nibbleD,
        input  frameValid, patternError, errorCount, scanStalled
    );
endinterface

// File: rtl/seven_seg_scan_decoder.sv
// Deglitches the multiplexed seven-segment bus, decodes each digit back to a
// nibble and publishes a four-digit frame once every digit has been seen.
module seven_seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                      clock,
    input logic                      reset,
    seven_seg_scan_decoder_if.slave  bus
);
    localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACCEPT_AT = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(TIMEOUT_CYCLES);

    // Returns {hit, nibble}; only exact active-low patterns are recognised.
    function automatic logic [4:0] decode_segments(input logic [7:0] seg);
        case (seg)
            8'b00010001: return {1'b1, 4'h0};
            8'b11010111: return {1'b1, 4'h1};
            8'b00110010: return {1'b1, 4'h2};
            8'b10010010: return {1'b1, 4'h3};
            8'b11010100: return {1'b1, 4'h4};
            8'b10011000: return {1'b1, 4'h5};
            8'b00011000: return {1'b1, 4'h6};
            8'b11010011: return {1'b1, 4'h7};
            8'b00010000: return {1'b1, 4'h8};
            8'b10010000: return {1'b1, 4'h9};
            8'b01010000: return {1'b1, 4'hA};
            8'b00011100: return {1'b1, 4'hB};
            8'b00111001: return {1'b1, 4'hC};
            8'b00010110: return {1'b1, 4'hD};
            8'b00111000: return {1'b1, 4'hE};
            8'b01111000: return {1'b1, 4'hF};
            default:     return 5'b0;
        endcase
    endfunction

    // Returns {valid, digit index}; exactly one enable bit must be low.
    function automatic logic [2:0] decode_enable(input logic [3:0] en);
        case (en)
            4'b1110: return {1'b1, 2'd0};
            4'b1101: return {1'b1, 2'd1};
            4'b1011: return {1'b1, 2'd2};
            4'b0111: return {1'b1, 2'd3};
            default: return 3'b0;
        endcase
    endfunction

    logic [3:0]       en_q, en_prev_q;
    logic [7:0]       data_q, data_prev_q;
    logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
    logic [3:0][3:0]  capture_q, capture_d;
    logic [3:0][3:0]  nibble_q, nibble_d;
    logic [3:0]       seen_mask_q, seen_mask_d;
    logic             frame_valid_q, frame_valid_d;
    logic             pattern_error_q, pattern_error_d;
    logic [7:0]       error_count_q, error_count_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             scan_stalled_q, scan_stalled_d;

    logic       same_pair, accept, en_ok, seg_ok, write_ok, miss;
    logic [1:0] digit;
    logic [3:0] nib;

    always_comb begin
        same_pair       = (en_q == en_prev_q) && (data_q == data_prev_q);
        stable_cnt_d    = '0;
        if (same_pair)
            stable_cnt_d = (stable_cnt_q == CNT_MAX) ? stable_cnt_q : stable_cnt_q + 1'b1;
        // The count passes ACCEPT_AT exactly once per stable run, so one acceptance per pair.
        accept          = same_pair && (stable_cnt_q == ACCEPT_AT);
        {en_ok, digit}  = decode_enable(en_q);
        {seg_ok, nib}   = decode_segments(data_q);
        write_ok        = accept && en_ok && seg_ok;
        miss            = accept && en_ok && !seg_ok;

        capture_d       = capture_q;
        nibble_d        = nibble_q;
        seen_mask_d     = seen_mask_q;
        frame_valid_d   = 1'b0;
        pattern_error_d = 1'b0;
        error_count_d   = error_count_q;
        timer_d         = timer_q;
        scan_stalled_d  = scan_stalled_q;

        if (write_ok)
            timer_d = '0;
        else if (timer_q != TMR_MAX)
            timer_d = timer_q + 1'b1;

        if (write_ok) begin
            scan_stalled_d = 1'b0;
        end else if (timer_d == TMR_MAX) begin
            scan_stalled_d = 1'b1;
            seen_mask_d    = '0;
        end

        if (write_ok) begin
            capture_d[digit]   = nib;
            seen_mask_d[digit] = 1'b1;
            if (seen_mask_d == 4'b1111) begin
                nibble_d      = capture_d;
                frame_valid_d = 1'b1;
                seen_mask_d   = '0;
            end
        end else if (miss) begin
            pattern_error_d    = 1'b1;
            seen_mask_d[digit] = 1'b0;
            if (error_count_q != 8'hFF)
                error_count_d = error_count_q + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            en_q            <= 4'b1111;
            en_prev_q       <= 4'b1111;
            data_q          <= 8'hFF;
            data_prev_q     <= 8'hFF;
            stable_cnt_q    <= '0;
            capture_q       <= '0;
            nibble_q        <= '0;
            seen_mask_q     <= '0;
            frame_valid_q   <= 1'b0;
            pattern_error_q <= 1'b0;
            error_count_q   <= '0;
            timer_q         <= '0;
            scan_stalled_q  <= 1'b0;
        end else begin
            en_q            <= bus.sevenSegmentEnable;
            en_prev_q       <= en_q;
            data_q          <= bus.sevenSegmentData;
            data_prev_q     <= data_q;
            stable_cnt_q    <= stable_cnt_d;
            capture_q       <= capture_d;
            nibble_q        <= nibble_d;
            seen_mask_q     <= seen_mask_d;
            frame_valid_q   <= frame_valid_d;
            pattern_error_q <= pattern_error_d;
            error_count_q   <= error_count_d;
            timer_q         <= timer_d;
            scan_stalled_q  <= scan_stalled_d;
        end
    end

    assign bus.nibbleA      = nibble_q[0];
    assign bus.nibbleB      = nibble_q[1];
    assign bus.nibbleC      = nibble_q[2];
    assign bus.nibbleD      = nibble_q[3];
    assign bus.frameValid   = frame_valid_q;
    assign bus.patternError = pattern_error_q;
    assign bus.errorCount   = error_count_q;
    assign bus.scanStalled  = scan_stalled_q;
endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed bench for seven_seg_scan_decoder: stimulus queues expected frames
// and pattern errors; a negedge monitor pops and compares them.
module tb_seven_seg_scan_decoder;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic        is_frame;
        logic [15:0] nibs;
        logic [7:0]  ec;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    seven_seg_scan_decoder_if bus ();

    seven_seg_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(1024)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    localparam logic [3:0] EN_A = 4'b1110, EN_B = 4'b1101, EN_C = 4'b1011, EN_D = 4'b0111;
    localparam logic [3:0] EN_OFF = 4'b1111;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic present(input logic [3:0] en, input logic [7:0] seg, input int n);
        bus.sevenSegmentEnable = en;
        bus.sevenSegmentData   = seg;
        repeat (n) @(negedge clock);
    endtask

    task automatic expect_frame(input logic [15:0] nibs, input logic [7:0] ec);
        exp_t e;
        e.is_frame = 1'b1; e.nibs = nibs; e.ec = ec;
        exp_q.push_back(e);
    endtask

    task automatic expect_error(input logic [7:0] ec);
        exp_t e;
        e.is_frame = 1'b0; e.nibs = 16'h0; e.ec = ec;
        exp_q.push_back(e);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_nibbles"}, {bus.nibbleA, bus.nibbleB, bus.nibbleC, bus.nibbleD}, 32'h0);
        check({tag, "_pulses"}, {bus.frameValid, bus.patternError}, 32'h0);
        check({tag, "_errorCount"}, bus.errorCount, 32'h0);
        check({tag, "_scanStalled"}, bus.scanStalled, 32'h0);
    endtask

    // Scoreboard monitor: every output pulse must match the head of the queue.
    always @(negedge clock) begin
        if (!reset && (bus.frameValid || bus.patternError)) begin
            checks++;
            if (bus.frameValid && bus.patternError) begin
                errors++;
                $display("FAIL pulse_overlap: frameValid=1 patternError=1 expected one of them");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: frameValid=%0b patternError=%0b expected none",
                         bus.frameValid, bus.patternError);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.frameValid !== mon_e.is_frame || bus.errorCount !== mon_e.ec ||
                    (mon_e.is_frame &&
                     {bus.nibbleA, bus.nibbleB, bus.nibbleC, bus.nibbleD} !== mon_e.nibs)) begin
                    errors++;
                    $display("FAIL scoreboard: got frame=%0b nibs=%h ec=%0d expected frame=%0b nibs=%h ec=%0d",
                             bus.frameValid, {bus.nibbleA, bus.nibbleB, bus.nibbleC, bus.nibbleD},
                             bus.errorCount, mon_e.is_frame, mon_e.nibs, mon_e.ec);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sevenSegmentEnable = EN_OFF;
        bus.sevenSegmentData   = 8'hFF;
        repeat (3) @(negedge clock);
        check_outputs_zero("reset");
        reset = 1'b0;
        present(EN_OFF, 8'hFF, 4);

        // Basic scan: 3, A, 0, F
        present(EN_A, 8'b10010010, 8);
        present(EN_B, 8'b01010000, 8);
        present(EN_C, 8'b00010001, 8);
        expect_frame(16'h3A0F, 8'd0);
        present(EN_D, 8'b01111000, 8);
        check("scan_errorCount", bus.errorCount, 32'd0);
        check("scan_nibbles_hold", {bus.nibbleA, bus.nibbleB, bus.nibbleC, bus.nibbleD}, 32'h3A0F);

        // Stability filter: 3-cycle D is dropped, exact 4-cycle D completes the frame at e+4
        present(EN_A, 8'b10011000, 8);
        present(EN_B, 8'b00011000, 8);
        present(EN_C, 8'b11010011, 8);
        present(EN_D, 8'b00111000, 3);
        present(EN_OFF, 8'hFF, 8);
        check("short_hold_no_frame", {bus.nibbleA, bus.nibbleB, bus.nibbleC, bus.nibbleD}, 32'h3A0F);
        expect_frame(16'h567E, 8'd0);
        bus.sevenSegmentEnable = EN_D;
        bus.sevenSegmentData   = 8'b00111000;
        repeat (4) @(posedge clock);
        #1 check("accept_before_e4", bus.frameValid, 32'd0);
        @(negedge clock);
        bus.sevenSegmentEnable = EN_OFF;
        bus.sevenSegmentData   = 8'hFF;
        @(posedge clock);
        #1 check("accept_at_e4", bus.frameValid, 32'd1);
        check("accept_at_e4_nibs", {bus.nibbleA, bus.nibbleB, bus.nibbleC, bus.nibbleD}, 32'h567E);
        present(EN_OFF, 8'hFF, 4);

        // Pattern miss clears B's seen bit; D alone must not complete the frame
        present(EN_A, 8'b11010111, 8);
        present(EN_C, 8'b00110010, 8);
        expect_error(8'd1);
        present(EN_B, 8'hFF, 8);
        check("miss_errorCount", bus.errorCount, 32'd1);
        present(EN_D, 8'b11010011, 8);
        check("miss_no_frame_yet", exp_q.size(), 32'd0);
        expect_frame(16'h1527, 8'd1);
        present(EN_B, 8'b10011000, 8);

        // Mid-frame reset
        present(EN_A, 8'b11010100, 8);
        present(EN_B, 8'b00011000, 8);
        present(EN_C, 8'b00111000, 8);
        reset = 1'b1;
        #1 check_outputs_zero("midreset");
        repeat (2) @(negedge clock);
        check_outputs_zero("midreset_hold");
        reset = 1'b0;
        present(EN_A, 8'b00111001, 8);
        present(EN_B, 8'b11010111, 8);
        present(EN_C, 8'b00110010, 8);
        expect_frame(16'hC123, 8'd0);
        present(EN_D, 8'b10010010, 8);

        // Stall timer from reset release, then mask clear on expiry
        reset = 1'b1;
        bus.sevenSegmentEnable = EN_OFF;
        bus.sevenSegmentData   = 8'hFF;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (1023) @(posedge clock);
        #1 check("stall_before_1024", bus.scanStalled, 32'd0);
        @(posedge clock);
        #1 check("stall_at_1024", bus.scanStalled, 32'd1);
        @(negedge clock);
        present(EN_A, 8'b00010000, 8);
        check("stall_cleared_by_write", bus.scanStalled, 32'd0);
        present(EN_B, 8'b10010000, 8);
        present(EN_C, 8'b00011100, 8);
        present(EN_OFF, 8'hFF, 1100);
        check("stall_after_idle", bus.scanStalled, 32'd1);
        present(EN_D, 8'b00010110, 8);
        check("stall_d_no_frame", {bus.nibbleA, bus.nibbleB, bus.nibbleC, bus.nibbleD}, 32'h0);
        present(EN_A, 8'b00010000, 8);
        present(EN_B, 8'b10010000, 8);
        expect_frame(16'h89BD, 8'd0);
        present(EN_C, 8'b00011100, 8);

        // errorCount saturation
        for (int i = 1; i <= 300; i++) begin
            expect_error((i > 255) ? 8'd255 : 8'(i));
            present(EN_A, 8'h00, 4);
            present(EN_OFF, 8'hFF, 4);
        end
        check("saturated_errorCount", bus.errorCount, 32'd255);
        present(EN_OFF, 8'hFF, 8);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
